// File: rtl/pipe_skid_stage_pkg.sv
// Shared pipeline definitions: skid stage state encoding and counter width.
package pipe_skid_stage_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL1 = 2'd1,
        ST_FULL2 = 2'd2
    } skid_state_t;

    localparam int BUBBLE_CNT_W = 16;

    // The state encoding doubles as the number of held beats.
    function automatic logic [1:0] state_occupancy(input skid_state_t s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and a synchronous clear.
module pipe_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, stopping at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage: two-entry skid buffer (registered in_ready) or
// single-entry register (combinational in_ready), with flush and a bubble counter.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SKID  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    input  logic                    out_ready,
    input  logic                    flush,
    output logic [1:0]              occupancy,
    output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

    logic bubble;

    assign bubble = out_ready && !out_valid;

    pipe_sat_counter #(
        .WIDTH(BUBBLE_CNT_W)
    ) u_bubble_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(1'b0),
        .inc  (bubble),
        .count(bubble_cnt)
    );

    generate
        if (SKID != 0) begin : g_skid
            skid_state_t      state_q;
            skid_state_t      state_d;
            logic [WIDTH-1:0] main_q;
            logic [WIDTH-1:0] skid_q;
            logic             ready_q;
            logic             accept;
            logic             fire;

            assign accept = in_valid && ready_q && !flush;
            assign fire   = (state_q != ST_EMPTY) && out_ready;

            // Next state from accept/fire; flush always returns to EMPTY.
            always_comb begin
                state_d = state_q;
                case (state_q)
                    ST_EMPTY: if (accept) state_d = ST_FULL1;
                    ST_FULL1: begin
                        if (accept && !fire)      state_d = ST_FULL2;
                        else if (fire && !accept) state_d = ST_EMPTY;
                    end
                    ST_FULL2: if (fire) state_d = ST_FULL1;
                    default:  state_d = ST_EMPTY;
                endcase
                if (flush) state_d = ST_EMPTY;
            end

            // State register; in_ready is precomputed so it never depends on out_ready this cycle.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_q <= ST_EMPTY;
                    ready_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    ready_q <= (state_d != ST_FULL2);
                end
            end

            // Payload registers: main feeds the output, skid catches a beat while main is stalled.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    main_q <= '0;
                    skid_q <= '0;
                end else if (flush) begin
                    skid_q <= '0;
                end else begin
                    case (state_q)
                        ST_EMPTY: if (accept) main_q <= in_data;
                        ST_FULL1: begin
                            if (accept && fire)  main_q <= in_data;
                            else if (accept)     skid_q <= in_data;
                        end
                        ST_FULL2: begin
                            if (fire) begin
                                main_q <= skid_q;
                                skid_q <= '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            assign in_ready  = ready_q;
            assign out_valid = (state_q != ST_EMPTY);
            assign out_data  = main_q;
            assign occupancy = state_occupancy(state_q);
        end else begin : g_single
            logic             valid_q;
            logic             en_q;
            logic [WIDTH-1:0] data_q;
            logic             accept;

            assign in_ready = en_q && (!valid_q || out_ready);
            assign accept   = in_valid && in_ready && !flush;

            // Single holding register; en_q keeps in_ready low while in reset.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    en_q    <= 1'b0;
                    data_q  <= '0;
                end else begin
                    en_q <= 1'b1;
                    if (flush) begin
                        valid_q <= 1'b0;
                    end else if (accept) begin
                        valid_q <= 1'b1;
                        data_q  <= in_data;
                    end else if (valid_q && out_ready) begin
                        valid_q <= 1'b0;
                    end
                end
            end

            assign out_valid = valid_q;
            assign out_data  = data_q;
            assign occupancy = {1'b0, valid_q};
        end
    endgenerate

endmodule
